// File: rtl/rst_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
// Imported by the sequencer top and its synchroniser.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ST_RESET,
    ST_SEQ,
    ST_RUN,
    ST_HOLD
  } state_t;

  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/reset_sync.sv
// Async-assert / sync-deassert reset synchroniser.
// Output is active-low and goes high STAGES edges after i_rst_n rises.
module reset_sync #(
  parameter int STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_n
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_sync <= '0;
    else          r_sync <= {r_sync[STAGES-2:0], 1'b1};
  end

  assign o_rst_n = r_sync[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged domain-reset release with software hold and heartbeat LED.
// rst_out bits clear in ascending order; all set together on any reset.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int NUM_CHANNELS  = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STAGE_DELAY   = 16,
  parameter int SWRST_HOLD    = 8,
  parameter int LED_DIV_WIDTH = 24
) (
  input  logic                                    sysclk,
  input  logic                                    rst,
  input  logic                                    sw_rst_req,
  output logic [NUM_CHANNELS-1:0]                 rst_out,
  output logic                                    all_ready,
  output logic [$clog2(NUM_CHANNELS+1)-1:0]       stage_idx,
  output logic                                    led
);

  localparam int DW = cw(STAGE_DELAY);
  localparam int HW = cw(SWRST_HOLD);
  localparam int SW = $clog2(NUM_CHANNELS + 1);

  state_t                   r_state;
  logic [NUM_CHANNELS-1:0]  r_rst_out;
  logic                     r_ready;
  logic [SW-1:0]            r_stage;
  logic                     r_led;
  logic [DW-1:0]            r_dcnt;
  logic [HW-1:0]            r_hcnt;
  logic [LED_DIV_WIDTH-1:0] r_hb;
  logic                     w_sync_n;
  logic                     w_sw_hold;

  reset_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk   (sysclk),
    .i_rst_n (rst),
    .o_rst_n (w_sync_n)
  );

  assign w_sw_hold = sw_rst_req &&
                     (r_state == ST_SEQ || r_state == ST_RUN);

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_RESET;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_stage   <= '0;
      r_led     <= 1'b0;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
      r_hb      <= '0;
    end else if (w_sw_hold) begin
      r_state   <= ST_HOLD;
      r_rst_out <= '1;
      r_ready   <= 1'b0;
      r_stage   <= '0;
      r_led     <= 1'b1;
      r_dcnt    <= '0;
      r_hcnt    <= '0;
    end else begin
      unique case (r_state)
        ST_RESET: begin
          if (w_sync_n) begin
            r_state <= ST_SEQ;
            r_stage <= '0;
            r_dcnt  <= '0;
          end
        end
        ST_SEQ: begin
          if (r_dcnt == DW'(STAGE_DELAY - 1)) begin
            r_dcnt    <= '0;
            // Shifting zeros in from bit 0 keeps release order strict.
            r_rst_out <= r_rst_out << 1;
            r_stage   <= r_stage + 1'b1;
            if (r_stage == SW'(NUM_CHANNELS - 1)) begin
              r_state <= ST_RUN;
              r_ready <= 1'b1;
              r_hb    <= '0;
            end
          end else begin
            r_dcnt <= r_dcnt + 1'b1;
          end
        end
        ST_RUN: begin
          r_hb <= r_hb + 1'b1;
          if (&r_hb) r_led <= ~r_led;
        end
        ST_HOLD: begin
          if (sw_rst_req) begin
            r_hcnt <= '0;
          end else if (r_hcnt == HW'(SWRST_HOLD - 1)) begin
            r_state <= ST_SEQ;
            r_led   <= 1'b0;
            r_dcnt  <= '0;
            r_hcnt  <= '0;
          end else begin
            r_hcnt <= r_hcnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign rst_out   = r_rst_out;
  assign all_ready = r_ready;
  assign stage_idx = r_stage;
  assign led       = r_led;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: default sequencer (LED_DIV_WIDTH=4) plus a
// minimal instance (1 channel, delay 1, hold 1) sharing clock and rst.
module tb_reset_sequencer;

  logic       sysclk = 1'b0;
  logic       rst = 1'b0;
  logic       sw0 = 1'b0;
  logic       sw1 = 1'b0;
  logic [3:0] ro0;
  logic       rdy0;
  logic [2:0] st0;
  logic       led0;
  logic [0:0] ro1;
  logic       rdy1;
  logic [0:0] st1;
  logic       led1;

  int n_vec = 0;
  int n_err = 0;

  always #5 sysclk = ~sysclk;

  reset_sequencer #(
    .NUM_CHANNELS  (4),
    .SYNC_STAGES   (2),
    .STAGE_DELAY   (16),
    .SWRST_HOLD    (8),
    .LED_DIV_WIDTH (4)
  ) dut0 (
    .sysclk     (sysclk),
    .rst        (rst),
    .sw_rst_req (sw0),
    .rst_out    (ro0),
    .all_ready  (rdy0),
    .stage_idx  (st0),
    .led        (led0)
  );

  reset_sequencer #(
    .NUM_CHANNELS  (1),
    .SYNC_STAGES   (2),
    .STAGE_DELAY   (1),
    .SWRST_HOLD    (1),
    .LED_DIV_WIDTH (4)
  ) dut1 (
    .sysclk     (sysclk),
    .rst        (rst),
    .sw_rst_req (sw1),
    .rst_out    (ro1),
    .all_ready  (rdy1),
    .stage_idx  (st1),
    .led        (led1)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge sysclk);
    #1;
  endtask

  // Packs {rst_out, all_ready, stage_idx, led} of dut0.
  function automatic logic [8:0] s0();
    return {ro0, rdy0, st0, led0};
  endfunction

  task automatic test_reset();
    tick(2);
    n_vec++;
    if (s0() !== {4'b1111, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_hold0: got %b want %b", s0(), 9'b1111_0_000_0);
    end
    n_vec++;
    if ({ro1, rdy1, st1, led1} !== 4'b1_0_0_0) begin
      n_err++;
      $display("FAIL reset_hold1: got %b want 1000", {ro1, rdy1, st1, led1});
    end
  endtask

  // Releases rst mid-cycle and returns at E0+1ns (3rd edge).
  task automatic release_rst();
    @(negedge sysclk);
    rst = 1'b1;
    tick(2);
    n_vec++;
    if (ro0 !== 4'b1111) begin
      n_err++;
      $display("FAIL sync_wait: got %b want 1111", ro0);
    end
    tick(1);
  endtask

  task automatic test_power_on();
    release_rst();
    n_vec++;
    if (ro0 !== 4'b1111 || st0 !== 3'd0) begin
      n_err++;
      $display("FAIL e0_state: got %b/%0d want 1111/0", ro0, st0);
    end
    tick(1);
    n_vec++;
    if ({ro1, rdy1, st1} !== 3'b0_1_1) begin
      n_err++;
      $display("FAIL min_release: got %b want 011", {ro1, rdy1, st1});
    end
    tick(14);
    n_vec++;
    if (ro0 !== 4'b1111) begin
      n_err++;
      $display("FAIL pre_rel0: got %b want 1111", ro0);
    end
    tick(1);
    n_vec++;
    if (ro0 !== 4'b1110 || st0 !== 3'd1) begin
      n_err++;
      $display("FAIL rel0: got %b/%0d want 1110/1", ro0, st0);
    end
    tick(16);
    n_vec++;
    if (ro0 !== 4'b1100 || st0 !== 3'd2) begin
      n_err++;
      $display("FAIL rel1: got %b/%0d want 1100/2", ro0, st0);
    end
    tick(16);
    n_vec++;
    if (ro0 !== 4'b1000 || st0 !== 3'd3 || rdy0 !== 1'b0) begin
      n_err++;
      $display("FAIL rel2: got %b/%0d/%b want 1000/3/0", ro0, st0, rdy0);
    end
    tick(16);
    n_vec++;
    if (s0() !== {4'b0000, 1'b1, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL rel3: got %b want %b", s0(), 9'b0000_1_100_0);
    end
  endtask

  task automatic test_heartbeat();
    tick(15);
    n_vec++;
    if (led0 !== 1'b0) begin
      n_err++;
      $display("FAIL hb_pre: got %b want 0", led0);
    end
    tick(1);
    n_vec++;
    if (led0 !== 1'b1) begin
      n_err++;
      $display("FAIL hb_tog1: got %b want 1", led0);
    end
    tick(15);
    n_vec++;
    if (led0 !== 1'b1) begin
      n_err++;
      $display("FAIL hb_mid: got %b want 1", led0);
    end
    tick(1);
    n_vec++;
    if (led0 !== 1'b0) begin
      n_err++;
      $display("FAIL hb_tog2: got %b want 0", led0);
    end
  endtask

  task automatic test_sw_rst_run();
    sw0 = 1'b1;
    tick(1);
    sw0 = 1'b0;
    n_vec++;
    if (s0() !== {4'b1111, 1'b0, 3'd0, 1'b1}) begin
      n_err++;
      $display("FAIL swr_entry: got %b want %b", s0(), 9'b1111_0_000_1);
    end
    tick(7);
    n_vec++;
    if (led0 !== 1'b1) begin
      n_err++;
      $display("FAIL swr_hold: got led %b want 1", led0);
    end
    tick(1);
    n_vec++;
    if (led0 !== 1'b0 || ro0 !== 4'b1111) begin
      n_err++;
      $display("FAIL swr_exit: got %b/%b want 0/1111", led0, ro0);
    end
    tick(15);
    n_vec++;
    if (ro0 !== 4'b1111) begin
      n_err++;
      $display("FAIL swr_pre: got %b want 1111", ro0);
    end
    tick(1);
    n_vec++;
    if (ro0 !== 4'b1110 || st0 !== 3'd1) begin
      n_err++;
      $display("FAIL swr_rel0: got %b/%0d want 1110/1", ro0, st0);
    end
  endtask

  task automatic test_sw_rst_midseq();
    tick(16);
    n_vec++;
    if (st0 !== 3'd2) begin
      n_err++;
      $display("FAIL mid_stage2: got %0d want 2", st0);
    end
    sw0 = 1'b1;
    tick(1);
    sw0 = 1'b0;
    n_vec++;
    if (ro0 !== 4'b1111 || st0 !== 3'd0 || led0 !== 1'b1) begin
      n_err++;
      $display("FAIL mid_entry: got %b/%0d/%b want 1111/0/1", ro0, st0, led0);
    end
    tick(8 + 16);
    n_vec++;
    if (ro0 !== 4'b1110) begin
      n_err++;
      $display("FAIL mid_rel0: got %b want 1110", ro0);
    end
    tick(48);
    n_vec++;
    if (s0() !== {4'b0000, 1'b1, 3'd4, 1'b0}) begin
      n_err++;
      $display("FAIL mid_done: got %b want %b", s0(), 9'b0000_1_100_0);
    end
  endtask

  task automatic test_async_reset();
    sw0 = 1'b1;
    tick(1);
    sw0 = 1'b0;
    tick(8 + 20);
    n_vec++;
    if (ro0 !== 4'b1110) begin
      n_err++;
      $display("FAIL ar_setup: got %b want 1110", ro0);
    end
    #3;
    rst = 1'b0;
    #1;
    n_vec++;
    if (s0() !== {4'b1111, 1'b0, 3'd0, 1'b0}) begin
      n_err++;
      $display("FAIL ar_immed: got %b want %b", s0(), 9'b1111_0_000_0);
    end
    sw0 = 1'b1;
    sw1 = 1'b1;
    tick(2);
    sw0 = 1'b0;
    sw1 = 1'b0;
    n_vec++;
    if (s0() !== {4'b1111, 1'b0, 3'd0, 1'b0} || led1 !== 1'b0) begin
      n_err++;
      $display("FAIL ar_swign: got %b/%b want %b/0", s0(), led1,
               9'b1111_0_000_0);
    end
  endtask

  task automatic test_param_sweep();
    release_rst();
    n_vec++;
    if (ro1 !== 1'b1 || rdy1 !== 1'b0) begin
      n_err++;
      $display("FAIL pw_e0: got %b%b want 10", ro1, rdy1);
    end
    tick(1);
    n_vec++;
    if (ro1 !== 1'b0 || rdy1 !== 1'b1) begin
      n_err++;
      $display("FAIL pw_rel: got %b%b want 01", ro1, rdy1);
    end
    tick(3);
    sw1 = 1'b1;
    tick(1);
    sw1 = 1'b0;
    n_vec++;
    if ({ro1, rdy1, st1, led1} !== 4'b1_0_0_1) begin
      n_err++;
      $display("FAIL pw_hold: got %b want 1001", {ro1, rdy1, st1, led1});
    end
    tick(1);
    n_vec++;
    if ({ro1, rdy1, led1} !== 3'b1_0_0) begin
      n_err++;
      $display("FAIL pw_exit: got %b want 100", {ro1, rdy1, led1});
    end
    tick(1);
    n_vec++;
    if ({ro1, rdy1, st1} !== 3'b0_1_1) begin
      n_err++;
      $display("FAIL pw_rerel: got %b want 011", {ro1, rdy1, st1});
    end
  endtask

  initial begin
    test_reset();
    test_power_on();
    test_heartbeat();
    test_sw_rst_run();
    test_sw_rst_midseq();
    test_async_reset();
    test_param_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Parametrised reset and heartbeat controller that sits between the board reset/clock pins and the CPU core plus its peripheral domains (pmem, dmem, IO).
- Releases NUM_CHANNELS active-high domain resets one after another in a fixed, ordered staging, with a programmable delay between releases.
- Supports a synchronous software reset request.
- Drives the status LED: dark while resetting, solid during software hold, blinking when all domains run.

Parameters:
- NUM_CHANNELS, 4, number of staged reset outputs; legal range 1..16.
- SYNC_STAGES, 2, flops in the reset-deassertion synchroniser; minimum 2.
- STAGE_DELAY, 16, cycles between successive channel releases; minimum 1.
- SWRST_HOLD, 8, cycles all channels stay asserted after a software reset request; minimum 1.
- LED_DIV_WIDTH, 24, width of the heartbeat counter; led toggles on counter wrap.

Ports:
- sysclk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low board reset.
- sw_rst_req  in  1  synchronous software reset request; single-cycle pulse, level also accepted.
- rst_out  out  NUM_CHANNELS  active-high domain resets; bit 0 is released first.
- all_ready  out  1  high only in RUN.
- stage_idx  out  $clog2(NUM_CHANNELS+1)  number of channels released so far.
- led  out  1  status LED.

Behaviour:
- Reset:
  - rst low asynchronously clears the sync chain and forces the FSM to RESET.
  - While rst is low: rst_out = all ones, all_ready = 0, stage_idx = 0, led = 0, all counters = 0.
- Deassertion:
  - rst rising is synchronised through SYNC_STAGES flops.
  - FSM leaves RESET on the first edge where the synchroniser output is 1. Call this edge E0; with SYNC_STAGES = 2, E0 is the 3rd rising edge after rst rises.
- States:
  - RESET -> SEQ at E0. Stage counter is cleared at E0.
  - SEQ:
    - Delay counter counts 0..STAGE_DELAY-1.
    - On wrap, rst_out[stage_idx] clears and stage_idx increments.
    - Result: rst_out[k] deasserts at edge E0 + (k+1)*STAGE_DELAY.
    - When stage_idx reaches NUM_CHANNELS, go to RUN. all_ready rises on the same edge as the last release.
  - RUN: hold; heartbeat counter runs.
  - HOLD:
    - Entered from SEQ or RUN on any edge with sw_rst_req = 1.
    - On that same edge: rst_out = all ones, all_ready = 0, stage_idx = 0.
    - Hold counter runs SWRST_HOLD cycles, then the FSM goes to SEQ and restarts staging from channel 0.
    - sw_rst_req while in HOLD restarts the hold count.
- Simultaneous events: asynchronous rst dominates everything. In RESET, sw_rst_req is ignored.
- Ordering: rst_out bits only ever clear in ascending index order, and all set together. No bit is ever released out of order or glitches.
- LED:
  - RESET/SEQ: 0.
  - HOLD: 1.
  - RUN: toggles each time the LED_DIV_WIDTH-bit counter wraps. The counter is cleared on RUN entry, so the first toggle is at 2^LED_DIV_WIDTH cycles after entry.
- Outputs: all outputs are registered. No combinational path from sw_rst_req to any output.

Decomposition:
- Shared package (rst_seq_pkg):
  - FSM state encoding: RESET, SEQ, RUN, HOLD.
  - Localparam helpers for counter widths: clog2 of STAGE_DELAY, SWRST_HOLD and NUM_CHANNELS+1.
- One sub-module, reset_sync: an SYNC_STAGES-deep asynchronous-assert / synchronous-deassert synchroniser. It is reused later for IO-domain resets.
- FSM, counters and LED divider live in the top module.

Test Plan:
- Power-on, defaults with LED_DIV_WIDTH = 4:
  - rst low for 2 cycles, then high -> rst_out = 4'b1111 until E0 (3rd edge).
  - Releases at E0+16, +32, +48, +64, in order 1110, 1100, 1000, 0000.
  - all_ready = 1 at E0+64; stage_idx = 4.
- Heartbeat: in RUN with LED_DIV_WIDTH = 4 -> led toggles every 16 cycles; first toggle 16 cycles after RUN entry.
- Software reset in RUN: 1-cycle sw_rst_req pulse -> next edge rst_out = 1111, all_ready = 0, led = 1.
  - After 8 cycles in HOLD, staging restarts; rst_out[0] clears 16 cycles after HOLD exit.
- sw_rst_req mid-sequence: pulse when stage_idx = 2 -> rst_out returns to 1111 and stage_idx = 0; full restaging follows.
- Asynchronous reset mid-operation: rst low between clock edges while in SEQ -> rst_out = 1111 and led = 0 immediately, with no clock edge.
  - A further sw_rst_req while rst is low has no effect.
- Parameter sweep: NUM_CHANNELS = 1, STAGE_DELAY = 1, SWRST_HOLD = 1 -> rst_out[0] clears at E0+1 with all_ready high on the same edge; a HOLD lasts exactly 1 cycle.
